// File: rtl/jtdd_prog_sched_pkg.sv
// Shared types and constants for the ROM-download write scheduler.
//   sched_state_t : FSM states of the SDRAM write sequencer
//   prog_entry_t  : one captured download write (word address, byte, active-low mask)
//   is_noop_mask  : true when an entry enables neither byte and needs no SDRAM access
package jtdd_prog_sched_pkg;

    localparam int SDRAM_AW = 22;
    localparam int ENTRY_W  = SDRAM_AW + 8 + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [SDRAM_AW-1:0] addr;
        logic [7:0]          data;
        logic [1:0]          mask;
    } prog_entry_t;

    function automatic logic is_noop_mask(input logic [1:0] mask);
        return mask == 2'b11;
    endfunction

endpackage

// File: rtl/jtdd_prog_fifo.sv
// Small synchronous FIFO holding captured download writes until SDRAM accepts them.
//   clk, rst   : clock, asynchronous active-high reset (pointers only)
//   push, din  : write request and entry; ignored when full unless a pop happens too
//   pop        : discard the head entry; ignored when empty
//   dout       : head entry (valid while empty=0)
//   full/empty : occupancy flags derived from the pointers
module jtdd_prog_fifo #(
    parameter int AW = 2,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO still succeeds when the head leaves in the same cycle:
    // the freed slot is exactly the one the write pointer addresses.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/jtdd_prog_sched.sv
// Sequences ROM-download writes into the SDRAM controller write port.
// Every rising edge of prog_we captures {addr,data,mask} into a FIFO; entries are
// replayed as req/ack/rdy write transactions, decoupling ioctl pacing from SDRAM
// latency. dwnld_busy stays high until the FIFO has drained.
//   clk, rst                  : clock, asynchronous active-high reset
//   downloading               : ioctl download window; its rising edge clears the errors
//   prog_we/addr/data/mask    : write strobe and payload (mask active-low)
//   prog_full                 : FIFO full, advisory back-pressure
//   sdram_req/addr/din/wrmask : registered write request to the SDRAM controller
//   sdram_ack, sdram_rdy      : one-cycle pulses: request accepted / write committed
//   dwnld_busy                : downloading, entries pending, or a transaction in flight
//   ovf_err, tout_err         : sticky: entry dropped on full FIFO / rdy never arrived
module jtdd_prog_sched
    import jtdd_prog_sched_pkg::*;
#(
    parameter int FIFO_AW = 2,
    parameter int TOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic        prog_we,
    input  logic [21:0] prog_addr,
    input  logic [7:0]  prog_data,
    input  logic [1:0]  prog_mask,
    output logic        prog_full,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    output logic [15:0] sdram_din,
    output logic [1:0]  sdram_wrmask,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    output logic        dwnld_busy,
    output logic        ovf_err,
    output logic        tout_err
);

    // The timer only has to count 0..TOUT-1 before the abort fires.
    localparam int TW = (TOUT > 1) ? $clog2(TOUT) : 1;
    localparam logic [TW-1:0] TOUT_LAST = TW'(TOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE = {{(TW-1){1'b0}}, 1'b1};

    sched_state_t        state_q, state_d;
    logic                req_q, req_d;
    logic [21:0]         addr_q, addr_d;
    logic [15:0]         din_q, din_d;
    logic [1:0]          mask_q, mask_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                ovf_q, ovf_d;
    logic                tout_q, tout_d;
    logic                prog_we_q;
    logic                downloading_q;

    logic                push_req;
    logic                dl_rise;
    logic                pop;
    logic                fifo_full, fifo_empty;
    prog_entry_t         push_entry, head_entry;

    assign push_req   = prog_we & ~prog_we_q;
    assign dl_rise    = downloading & ~downloading_q;
    assign push_entry = '{addr: prog_addr, data: prog_data, mask: prog_mask};

    jtdd_prog_fifo #(
        .AW (FIFO_AW),
        .DW (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The head entry stays in the FIFO for the whole transaction and is popped only
    // when the write is committed (or abandoned), so busy covers in-flight writes.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        din_d   = din_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        ovf_d   = ovf_q;
        tout_d  = tout_q;
        pop     = 1'b0;

        if (dl_rise) begin
            ovf_d  = 1'b0;
            tout_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (is_noop_mask(head_entry.mask)) begin
                        pop = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        addr_d  = head_entry.addr;
                        din_d   = {head_entry.data, head_entry.data};
                        mask_d  = head_entry.mask;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    timer_d = '0;
                    if (sdram_rdy) begin
                        pop     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (sdram_rdy) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == TOUT_LAST) begin
                    tout_d  = 1'b1;
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // A simultaneous pop frees a slot, so only an unmatched push into a full FIFO is lost.
        if (push_req && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            mask_q        <= 2'b11;
            timer_q       <= '0;
            ovf_q         <= 1'b0;
            tout_q        <= 1'b0;
            prog_we_q     <= 1'b0;
            downloading_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            mask_q        <= mask_d;
            timer_q       <= timer_d;
            ovf_q         <= ovf_d;
            tout_q        <= tout_d;
            prog_we_q     <= prog_we;
            downloading_q <= downloading;
        end
    end

    assign prog_full    = fifo_full;
    assign sdram_req    = req_q;
    assign sdram_addr   = addr_q;
    assign sdram_din    = din_q;
    assign sdram_wrmask = mask_q;
    assign ovf_err      = ovf_q;
    assign tout_err     = tout_q;
    assign dwnld_busy   = downloading | ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_jtdd_prog_sched.sv
// Directed bench for jtdd_prog_sched: single write, overflow burst, rdy timeout,
// no-op mask entries, a short ROM stream into an SDRAM image, and async reset mid-request.
module tb_jtdd_prog_sched;

    localparam int TOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic        prog_we = 1'b0;
    logic [21:0] prog_addr = '0;
    logic [7:0]  prog_data = '0;
    logic [1:0]  prog_mask = 2'b11;
    logic        prog_full;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic [15:0] sdram_din;
    logic [1:0]  sdram_wrmask;
    logic        sdram_ack = 1'b0;
    logic        sdram_rdy = 1'b0;
    logic        dwnld_busy;
    logic        ovf_err;
    logic        tout_err;

    int          vectorsApplied = 0;
    int          miscompares = 0;
    logic [15:0] sdramMem [32];

    jtdd_prog_sched #(
        .FIFO_AW (2),
        .TOUT    (TOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .downloading  (downloading),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_mask    (prog_mask),
        .prog_full    (prog_full),
        .sdram_req    (sdram_req),
        .sdram_addr   (sdram_addr),
        .sdram_din    (sdram_din),
        .sdram_wrmask (sdram_wrmask),
        .sdram_ack    (sdram_ack),
        .sdram_rdy    (sdram_rdy),
        .dwnld_busy   (dwnld_busy),
        .ovf_err      (ovf_err),
        .tout_err     (tout_err)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorsApplied++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One prog_we pulse (high one clock, low one clock); called and returns on a negedge.
    task automatic applyStimulus(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
        prog_addr = a;
        prog_data = d;
        prog_mask = m;
        prog_we   = 1'b1;
        @(negedge clk);
        prog_we   = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitReq();
        int n = 0;
        while (sdram_req !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_seen", 32'(sdram_req), 32'd1);
    endtask

    // SDRAM responder: ack one cycle after req is seen, rdy the cycle after ack.
    task automatic serviceWrite(output logic [21:0] a, output logic [15:0] d,
                                output logic [1:0] m);
        waitReq();
        a = sdram_addr;
        d = sdram_din;
        m = sdram_wrmask;
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        checkOutput("req_drop_on_ack", 32'(sdram_req), 32'd0);
        sdram_rdy = 1'b1;
        @(negedge clk);
        sdram_rdy = 1'b0;
    endtask

    function automatic logic [7:0] imgByte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 2));
    endfunction

    initial begin
        logic [21:0] sa;
        logic [15:0] sd;
        logic [1:0]  sm;

        // Reset state
        @(negedge clk);
        checkOutput("rst_req", 32'(sdram_req), 32'd0);
        checkOutput("rst_addr", 32'(sdram_addr), 32'd0);
        checkOutput("rst_din", 32'(sdram_din), 32'd0);
        checkOutput("rst_wrmask", 32'(sdram_wrmask), 32'd3);
        checkOutput("rst_busy", 32'(dwnld_busy), 32'd0);
        checkOutput("rst_full", 32'(prog_full), 32'd0);
        checkOutput("rst_errs", 32'({ovf_err, tout_err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single write: ack 3 cycles after req, rdy 3 cycles after ack
        $display("[TB] single write");
        downloading = 1'b1;
        @(negedge clk);
        prog_addr = 22'h00100;
        prog_data = 8'hA5;
        prog_mask = 2'b01;
        prog_we   = 1'b1;
        @(negedge clk);
        prog_we = 1'b0;
        checkOutput("t1_req_latency", 32'(sdram_req), 32'd0);
        @(negedge clk);
        checkOutput("t1_req", 32'(sdram_req), 32'd1);
        checkOutput("t1_addr", 32'(sdram_addr), 32'h00100);
        checkOutput("t1_din", 32'(sdram_din), 32'hA5A5);
        checkOutput("t1_wrmask", 32'(sdram_wrmask), 32'd1);
        @(negedge clk);
        checkOutput("t1_req_hold", 32'(sdram_req), 32'd1);
        @(negedge clk);
        checkOutput("t1_addr_hold", 32'(sdram_addr), 32'h00100);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        downloading = 1'b0;
        checkOutput("t1_req_after_ack", 32'(sdram_req), 32'd0);
        @(negedge clk);
        checkOutput("t1_busy_wait", 32'(dwnld_busy), 32'd1);
        @(negedge clk);
        sdram_rdy = 1'b1;
        @(negedge clk);
        sdram_rdy = 1'b0;
        checkOutput("t1_busy_done", 32'(dwnld_busy), 32'd0);
        checkOutput("t1_tout", 32'(tout_err), 32'd0);

        // Burst of 6 pushes with SDRAM stalled: 4 fit, 2 lost
        $display("[TB] overflow burst");
        downloading = 1'b1;
        @(negedge clk);
        applyStimulus(22'h200, 8'h10, 2'b10);
        applyStimulus(22'h201, 8'h11, 2'b10);
        applyStimulus(22'h202, 8'h12, 2'b10);
        checkOutput("t2_not_full_3", 32'(prog_full), 32'd0);
        applyStimulus(22'h203, 8'h13, 2'b10);
        checkOutput("t2_full_4", 32'(prog_full), 32'd1);
        checkOutput("t2_no_ovf_yet", 32'(ovf_err), 32'd0);
        applyStimulus(22'h204, 8'h14, 2'b10);
        checkOutput("t2_ovf", 32'(ovf_err), 32'd1);
        applyStimulus(22'h205, 8'h15, 2'b10);
        repeat (20) @(negedge clk);
        checkOutput("t2_req_stalled", 32'(sdram_req), 32'd1);
        checkOutput("t2_addr_stalled", 32'(sdram_addr), 32'h200);
        for (int k = 0; k < 4; k++) begin
            serviceWrite(sa, sd, sm);
            checkOutput("t2_order_addr", 32'(sa), 32'h200 + 32'(k));
            checkOutput("t2_order_din", 32'(sd), {16'h0, 8'h10 + 8'(k), 8'h10 + 8'(k)});
        end
        checkOutput("t2_full_drained", 32'(prog_full), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("t2_lost_no_req", 32'(sdram_req), 32'd0);
        checkOutput("t2_ovf_sticky", 32'(ovf_err), 32'd1);
        downloading = 1'b0;
        @(negedge clk);
        checkOutput("t2_busy_done", 32'(dwnld_busy), 32'd0);

        // rdy withheld: timeout exactly TOUT cycles after ack, next entry follows
        $display("[TB] rdy timeout");
        downloading = 1'b1;
        @(negedge clk);
        checkOutput("t4_ovf_cleared", 32'(ovf_err), 32'd0);
        applyStimulus(22'h300, 8'h31, 2'b10);
        applyStimulus(22'h301, 8'h32, 2'b10);
        waitReq();
        checkOutput("t4_addr_a", 32'(sdram_addr), 32'h300);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        checkOutput("t4_tout_start", 32'(tout_err), 32'd0);
        repeat (TOUT - 1) @(negedge clk);
        checkOutput("t4_tout_early", 32'(tout_err), 32'd0);
        @(negedge clk);
        checkOutput("t4_tout_set", 32'(tout_err), 32'd1);
        @(negedge clk);
        checkOutput("t4_next_req", 32'(sdram_req), 32'd1);
        checkOutput("t4_next_addr", 32'(sdram_addr), 32'h301);
        sdram_rdy = 1'b1;
        @(negedge clk);
        sdram_rdy = 1'b0;
        checkOutput("t4_rdy_in_req_ignored", 32'(sdram_req), 32'd1);
        serviceWrite(sa, sd, sm);
        checkOutput("t4_b_addr", 32'(sa), 32'h301);
        downloading = 1'b0;
        @(negedge clk);
        checkOutput("t4_busy_done", 32'(dwnld_busy), 32'd0);
        checkOutput("t4_tout_sticky", 32'(tout_err), 32'd1);

        // mask=2'b11 entry between two real writes is skipped
        $display("[TB] no-op mask entry");
        downloading = 1'b1;
        @(negedge clk);
        checkOutput("t6_tout_cleared", 32'(tout_err), 32'd0);
        applyStimulus(22'h400, 8'h41, 2'b10);
        applyStimulus(22'h401, 8'h42, 2'b11);
        applyStimulus(22'h402, 8'h43, 2'b01);
        serviceWrite(sa, sd, sm);
        checkOutput("t6_first_addr", 32'(sa), 32'h400);
        checkOutput("t6_first_mask", 32'(sm), 32'd2);
        serviceWrite(sa, sd, sm);
        checkOutput("t6_second_addr", 32'(sa), 32'h402);
        checkOutput("t6_second_mask", 32'(sm), 32'd1);
        checkOutput("t6_second_din", 32'(sd), 32'h4343);
        downloading = 1'b0;
        @(negedge clk);
        checkOutput("t6_busy_done", 32'(dwnld_busy), 32'd0);
        checkOutput("t6_no_extra_req", 32'(sdram_req), 32'd0);

        // ROM stream, one byte per 4 clocks, into a 32-word SDRAM image
        $display("[TB] rom stream");
        for (int w = 0; w < 32; w++) sdramMem[w] = 16'h0;
        downloading = 1'b1;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    applyStimulus(22'(i >> 1), imgByte(i), i[0] ? 2'b01 : 2'b10);
                    @(negedge clk);
                    @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < 64; j++) begin
                    serviceWrite(sa, sd, sm);
                    if (!sm[0]) sdramMem[sa[4:0]][7:0]  = sd[7:0];
                    if (!sm[1]) sdramMem[sa[4:0]][15:8] = sd[15:8];
                end
            end
        join
        for (int w = 0; w < 32; w++) begin
            checkOutput("t3_image", 32'(sdramMem[w]), {16'h0, imgByte(2 * w + 1), imgByte(2 * w)});
        end
        checkOutput("t3_ovf", 32'(ovf_err), 32'd0);
        checkOutput("t3_tout", 32'(tout_err), 32'd0);
        downloading = 1'b0;
        @(negedge clk);
        checkOutput("t3_busy_done", 32'(dwnld_busy), 32'd0);

        // Asynchronous reset while a request is pending
        $display("[TB] reset mid-request");
        downloading = 1'b1;
        @(negedge clk);
        applyStimulus(22'h500, 8'h5A, 2'b10);
        checkOutput("t5_req_before", 32'(sdram_req), 32'd1);
        #2;
        rst = 1'b1;
        downloading = 1'b0;
        #1;
        checkOutput("t5_req_async", 32'(sdram_req), 32'd0);
        checkOutput("t5_wrmask", 32'(sdram_wrmask), 32'd3);
        checkOutput("t5_addr", 32'(sdram_addr), 32'd0);
        checkOutput("t5_full", 32'(prog_full), 32'd0);
        checkOutput("t5_busy_empty", 32'(dwnld_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t5_no_replay", 32'(sdram_req), 32'd0);
        checkOutput("t5_busy_after", 32'(dwnld_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
